// File: rtl/bombe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bombe_pkg
// Brief   : Shared bombe types and defaults (tick period monitor FSM states).
// Revision: 1.0 - initial release
// ============================================================================
package bombe_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_MEASURE    = 2'd1,
    ST_TIMEOUT    = 2'd2
  } tpm_state_e;

  localparam int unsigned C_TPM_CNT_W_DEFAULT   = 25;
  localparam int unsigned C_TPM_TIMEOUT_DEFAULT = 20_000_000;

endpackage
`default_nettype wire

// File: rtl/sync_rise_detect.sv
`default_nettype none
// ============================================================================
// Module  : sync_rise_detect
// Brief   : Two-flop synchronizer plus delay flop; rise is a one-cycle pulse
//           on a synchronized rising edge of an asynchronous input.
// Revision: 1.0 - initial release
// ============================================================================
module sync_rise_detect (
  input  logic clk_in,
  input  logic resetn,
  input  logic async_in,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/tick_period_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tick_period_monitor
// Brief   : Measures the period of a slow asynchronous tick, emits a step
//           strobe per tick edge and flags a stalled tick source.
// Revision: 1.0 - initial release
// ============================================================================
module tick_period_monitor
  import bombe_pkg::*;
#(
  parameter int unsigned CNT_W   = C_TPM_CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = C_TPM_TIMEOUT_DEFAULT
) (
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             tick_in,
  output logic             step_pulse,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic             w_rise;
  tpm_state_e       r_state,      w_state_nxt;
  logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;
  logic [CNT_W-1:0] r_period,     w_period_nxt;
  logic             r_valid,      w_valid_nxt;
  logic             r_stalled,    w_stalled_nxt;
  logic             r_step;
  logic [15:0]      r_edge_count;

  sync_rise_detect u_sync (
    .clk_in   (clk_in),
    .resetn   (resetn),
    .async_in (tick_in),
    .rise     (w_rise)
  );

  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      r_state      <= ST_WAIT_FIRST;
      r_cnt        <= '0;
      r_period     <= '0;
      r_valid      <= 1'b0;
      r_stalled    <= 1'b0;
      r_step       <= 1'b0;
      r_edge_count <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_period     <= w_period_nxt;
      r_valid      <= w_valid_nxt;
      r_stalled    <= w_stalled_nxt;
      r_step       <= w_rise;
      r_edge_count <= w_rise ? r_edge_count + 16'd1 : r_edge_count;
    end
  end

  // A rise always takes priority over the timeout check, so an edge landing
  // exactly on cnt == TIMEOUT still yields a valid period.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_stalled_nxt = r_stalled;
    case (r_state)
      ST_WAIT_FIRST: begin
        w_cnt_nxt     = '0;
        w_stalled_nxt = 1'b0;
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = C_ONE;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_period_nxt = r_cnt;
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = C_ONE;
        end else if (r_cnt == C_TIMEOUT) begin
          w_state_nxt   = ST_TIMEOUT;
          w_stalled_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_TIMEOUT: begin
        if (w_rise) begin
          w_state_nxt   = ST_MEASURE;
          w_stalled_nxt = 1'b0;
          w_cnt_nxt     = C_ONE;
        end
      end
      default: begin
        w_state_nxt   = ST_WAIT_FIRST;
        w_cnt_nxt     = '0;
        w_stalled_nxt = 1'b0;
      end
    endcase
  end

  assign step_pulse   = r_step;
  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign stalled      = r_stalled;
  assign edge_count   = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_tick_period_monitor
// Brief   : Scoreboard bench for tick_period_monitor (CNT_W=8, TIMEOUT=100).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tick_period_monitor;

  localparam int unsigned C_CNT_W   = 8;
  localparam int          C_TIMEOUT = 100;

  logic               clk_in = 1'b0;
  logic               resetn;
  logic               tick_in;
  logic               step_pulse;
  logic [C_CNT_W-1:0] period_out;
  logic               period_valid;
  logic               stalled;
  logic [15:0]        edge_count;

  tick_period_monitor #(.CNT_W(C_CNT_W), .TIMEOUT(C_TIMEOUT)) dut (
    .clk_in       (clk_in),
    .resetn       (resetn),
    .tick_in      (tick_in),
    .step_pulse   (step_pulse),
    .period_out   (period_out),
    .period_valid (period_valid),
    .stalled      (stalled),
    .edge_count   (edge_count)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    logic               valid;
    logic [C_CNT_W-1:0] period;
    logic [15:0]        edges;
  } exp_t;

  exp_t               sb_q[$];
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 n_valid = 0;
  logic [15:0]        m_edges;
  logic [C_CNT_W-1:0] m_period;
  logic               m_have_prev;
  int                 m_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_edges     = 16'd0;
    m_period    = '0;
    m_have_prev = 1'b0;
    m_last      = 0;
  endtask

  // Called on a negedge; the DUT's first sampling edge follows, so the step
  // strobe is expected three posedges later.
  task automatic drive_tick();
    exp_t e;
    int   gap;
    gap     = cyc - m_last;
    m_edges = m_edges + 16'd1;
    e.valid = m_have_prev && (gap <= C_TIMEOUT);
    if (e.valid) m_period = C_CNT_W'(gap);
    e.cyc    = cyc + 3;
    e.period = m_period;
    e.edges  = m_edges;
    sb_q.push_back(e);
    m_have_prev = 1'b1;
    m_last      = cyc;
    tick_in = 1'b1;
    @(negedge clk_in);
    tick_in = 1'b0;
  endtask

  task automatic spaced_tick(input int n);
    drive_tick();
    repeat (n - 1) @(negedge clk_in);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_in);
    check_val("sb_drain", sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_step"},   step_pulse,   0);
    check_val({tag, "_period"}, period_out,   0);
    check_val({tag, "_valid"},  period_valid, 0);
    check_val({tag, "_stall"},  stalled,      0);
    check_val({tag, "_edges"},  edge_count,   0);
  endtask

  always @(negedge clk_in) begin
    if (resetn === 1'b1) begin
      if (period_valid === 1'b1) n_valid++;
      if (step_pulse === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_val("step_unexpected", step_pulse, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("step_cycle", cyc,          e.cyc);
          check_val("step_valid", period_valid, e.valid);
          check_val("step_period", period_out,  e.period);
          check_val("step_edges", edge_count,   e.edges);
          check_val("step_stall", stalled,      0);
        end
      end else if (period_valid === 1'b1) begin
        check_val("valid_without_step", period_valid, 0);
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_valid;
    resetn  = 1'b0;
    tick_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("rst");
    resetn = 1'b1;

    // Idle before any edge must never stall
    repeat (150) @(negedge clk_in);
    check_val("idle_stall", stalled, 0);
    check_val("idle_edges", edge_count, 0);

    // First edge: step only, no period; then 40-cycle spacing
    base_valid = n_valid;
    spaced_tick(40);
    check_val("first_edges", edge_count, 1);
    check_val("first_no_valid", n_valid - base_valid, 0);
    repeat (4) spaced_tick(40);
    drain();
    check_val("p40_valid_count", n_valid - base_valid, 4);
    check_val("p40_edges", edge_count, 5);

    // Stall after TIMEOUT cycles without an edge
    while (cyc < m_last + 102) @(negedge clk_in);
    check_val("pre_stall", stalled, 0);
    @(negedge clk_in);
    check_val("stall_set", stalled, 1);
    check_val("stall_period_held", period_out, 40);
    repeat (10) @(negedge clk_in);
    base_valid = n_valid;
    drive_tick();
    drain();
    check_val("stall_clear", stalled, 0);
    check_val("stall_no_valid", n_valid - base_valid, 0);
    check_val("stall_period_kept", period_out, 40);

    // Edge landing exactly on cnt == TIMEOUT wins over the stall
    repeat (5) @(negedge clk_in);
    spaced_tick(100);
    drive_tick();
    drain();
    check_val("bound_period", period_out, 100);
    check_val("bound_stall", stalled, 0);

    // Reset mid-period discards the partial count
    repeat (5) @(negedge clk_in);
    drive_tick();
    drain();
    while (cyc < m_last + 33) @(negedge clk_in);
    resetn = 1'b0;
    @(negedge clk_in);
    model_reset();
    check_reset_outputs("midrst");
    resetn = 1'b1;
    repeat (3) @(negedge clk_in);
    base_valid = n_valid;
    spaced_tick(40);
    drive_tick();
    drain();
    check_val("post_rst_valids", n_valid - base_valid, 1);
    check_val("post_rst_period", period_out, 40);

    // edge_count wrap
    force dut.r_edge_count = 16'hFFFF;
    @(negedge clk_in);
    release dut.r_edge_count;
    m_edges = 16'hFFFF;
    repeat (2) @(negedge clk_in);
    check_val("preload_edges", edge_count, 16'hFFFF);
    drive_tick();
    drain();
    check_val("wrap_edges", edge_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_period_monitor.md
TICK_PERIOD_MONITOR -- requirements
Module: tick_period_monitor

Interface
REQ-001 Parameter CNT_W, default 25: width of the period counter and of period_out.
REQ-002 Parameter TIMEOUT, default 25'd20_000_000: number of cycles without a tick edge before stall is declared; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-003 Port clk_in, input, 1: the single system clock (CLOCK_50); all logic on its rising edge.
REQ-004 Port resetn, input, 1: reset, synchronous and active-low.
REQ-005 Port tick_in, input, 1: slow divided clock from a rate divider; asynchronous to clk_in.
REQ-006 Port step_pulse, output, 1: one-cycle strobe per tick_in rising edge; drives bombe rotor stepping.
REQ-007 Port period_out, output, CNT_W: last measured tick period, in clk_in cycles.
REQ-008 Port period_valid, output, 1: one-cycle strobe when period_out updates.
REQ-009 Port stalled, output, 1: level; high while no tick edge has arrived within TIMEOUT cycles.
REQ-010 Port edge_count, output, 16: count of detected tick_in rising edges; wraps 16'hFFFF -> 0.

Function
REQ-011 Synchronize tick_in through two flops (s1, s2), then a third flop s3; define rise = s2 & ~s3.
REQ-012 Registered step_pulse = rise: high for exactly one cycle, starting at the 3rd clk_in edge, where the 1st edge is the one that first samples tick_in high.
REQ-013 A tick_in high pulse shorter than one clk_in period may be missed; no requirement on it.
REQ-014 FSM states: WAIT_FIRST, MEASURE, TIMEOUT.
REQ-015 WAIT_FIRST: cnt held 0, stalled 0; on rise -> MEASURE, cnt <= 1, no period_valid.
REQ-016 MEASURE: cnt increments by 1 per cycle; on rise -> period_out <= cnt, period_valid <= 1 next cycle, cnt <= 1, stay MEASURE.
REQ-017 MEASURE: when cnt == TIMEOUT and no rise in that cycle -> TIMEOUT, stalled <= 1, cnt held.
REQ-018 Simultaneous rise and cnt == TIMEOUT: rise wins; period reported as in REQ-016; no stall.
REQ-019 TIMEOUT: on rise -> MEASURE, stalled <= 0, cnt <= 1, period_out unchanged, no period_valid (the interval is invalid).
REQ-020 Result: period_out = number of clk_in cycles between consecutive rise cycles; cnt never wraps.
REQ-021 edge_count increments by 1 on every rise cycle, in all states; step_pulse and period_valid coincide in the same cycle when both occur.
REQ-022 Outputs are registered; there is no combinational path from tick_in to any output.

Reset
REQ-023 With resetn low at a clk_in edge: s1/s2/s3 = 0, FSM = WAIT_FIRST, cnt = 0, step_pulse = 0, period_out = 0, period_valid = 0, stalled = 0, edge_count = 0.
REQ-024 Reset mid-measurement discards the partial count; the first rise after release reports no period.
REQ-025 If tick_in is high when resetn releases, s3 = 0 causes one rise after synchronization; this rise counts as a real edge.

Structure
REQ-026 The FSM state encodings (2-bit) and the default TIMEOUT value belong in a shared bombe package.
REQ-027 Sub-module sync_rise_detect contains the s1/s2/s3 chain and produces rise; the bombe reuses it for other asynchronous inputs.
REQ-028 The implementation is a single clock domain with no gated or derived clocks.

Verification (simulation: TIMEOUT = 100, CNT_W = 8)
REQ-029 Reset, then tick_in high at cycle 10 -> step_pulse high only in cycle 12, edge_count = 1, no period_valid.
REQ-030 Rises spaced exactly 40 cycles apart, 5 edges -> four period_valid strobes, each with period_out = 40; edge_count = 5.
REQ-031 No rise for 100 cycles after an edge -> stalled = 1 at cycle 101; next rise -> stalled = 0, period_out unchanged, no period_valid.
REQ-032 Rise in the same cycle cnt reaches 100 -> period_out = 100, period_valid = 1, stalled stays 0.
REQ-033 resetn low for one cycle mid-period (cnt = 30) -> all outputs 0; the next edge gives no period; the following edge gives the correct period.
REQ-034 Preload 65535 edges -> the next rise gives edge_count = 0, step_pulse still asserted.
